// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: receive-side UART front end. Synchronises the serial line,
// finds start bits, samples every bit at mid-period from the programmed divider
// and hands one assembled frame plus error flags to the register block.
module uart_rx_deframer #(
  parameter int MAX_FRAME_SIZE = 11
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [15:0]               cr_clk_div_i,
  input  logic                      cr_ds_i,
  input  logic                      cr_s_i,
  input  logic [1:0]                cr_p_i,
  input  logic                      uart_rx_i,
  output logic [MAX_FRAME_SIZE-1:0] frame_o,
  output logic                      parity_o,
  output logic                      frame_error_o,
  output logic                      output_valid_o
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  logic        sync1_q;
  logic        sync2_q;
  logic        prev_q;
  logic [1:0]  warm_q;
  logic        armed_q;

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic [7:0]  data_q;
  logic        par_bit_q;
  logic        par_err_q;
  logic        stop1_q;
  logic        stop_idx_q;
  logic        stop_err_q;

  logic        start_edge;
  logic        sample_evt;
  logic        last_data;
  logic        stop1_fin;
  logic        stop2_fin;
  logic        ferr_fin;
  logic [15:0] half_div;

  // Two-flop synchroniser plus an edge-history flop. The reset value of 1 can
  // fake a falling edge when the line is low at reset release, so new starts
  // stay blocked until the synchronised line has been seen high after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      warm_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (warm_q != 2'd3) begin
        warm_q <= warm_q + 2'd1;
      end
      if ((warm_q == 2'd3) && sync2_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign half_div   = (cr_clk_div_i >> 1) - 16'd1;
  assign start_edge = armed_q && prev_q && !sync2_q && (cr_clk_div_i >= 16'd4);
  assign sample_evt = (state_q != IDLE) && (cnt_q == 16'd0);
  assign last_data  = cr_ds_i ? (idx_q == 3'd6) : (idx_q == 3'd7);

  // Final stop-bit values: with two stop bits the first one was captured
  // earlier, with one stop bit the second field reads as 1.
  assign stop1_fin = stop_idx_q ? stop1_q : sync2_q;
  assign stop2_fin = stop_idx_q ? sync2_q : 1'b1;
  assign ferr_fin  = stop_idx_q ? (stop_err_q | ~sync2_q) : ~sync2_q;

  // Frame FSM with baud counter; outputs are registered and held between strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      cnt_q          <= 16'd0;
      idx_q          <= 3'd0;
      data_q         <= 8'd0;
      par_bit_q      <= 1'b0;
      par_err_q      <= 1'b0;
      stop1_q        <= 1'b0;
      stop_idx_q     <= 1'b0;
      stop_err_q     <= 1'b0;
      frame_o        <= '0;
      parity_o       <= 1'b0;
      frame_error_o  <= 1'b0;
      output_valid_o <= 1'b0;
    end else begin
      output_valid_o <= 1'b0;
      if (state_q != IDLE) begin
        if (cnt_q != 16'd0) begin
          cnt_q <= cnt_q - 16'd1;
        end else begin
          cnt_q <= cr_clk_div_i - 16'd1;
        end
      end
      case (state_q)
        IDLE: begin
          if (start_edge) begin
            cnt_q      <= half_div;
            idx_q      <= 3'd0;
            data_q     <= 8'd0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            stop_err_q <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (sample_evt) begin
            if (sync2_q) begin
              state_q <= IDLE;
            end else begin
              idx_q   <= 3'd0;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (sample_evt) begin
            data_q[idx_q] <= sync2_q;
            if (last_data) begin
              state_q <= cr_p_i[1] ? PARITY : STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (sample_evt) begin
            par_bit_q <= sync2_q;
            par_err_q <= ((^data_q) ^ sync2_q) != cr_p_i[0];
            state_q   <= STOP;
          end
        end
        STOP: begin
          if (sample_evt) begin
            if (cr_s_i && !stop_idx_q) begin
              stop1_q    <= sync2_q;
              stop_err_q <= ~sync2_q;
              stop_idx_q <= 1'b1;
            end else begin
              frame_o        <= MAX_FRAME_SIZE'({stop2_fin, stop1_fin, par_bit_q, data_q});
              parity_o       <= par_err_q;
              frame_error_o  <= ferr_fin;
              output_valid_o <= 1'b1;
              state_q        <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
